// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and encodings for the RAT pipeline hazard controller.
// Optional feature macro used by this block: HAZ_PERF_CNT_EN.
package rat_pipe_pkg;

    typedef enum logic [1:0] {
        HZ_IDLE   = 2'd0,
        HZ_DRAIN  = 2'd1,
        HZ_INJECT = 2'd2,
        HZ_VEC    = 2'd3
    } hz_state_t;

    // Register-file write-back source select encoding
    localparam logic [1:0] RF_SRC_ALU = 2'd0;
    localparam logic [1:0] RF_SRC_SCR = 2'd1;
    localparam logic [1:0] RF_SRC_SP  = 2'd2;
    localparam logic [1:0] RF_SRC_IN  = 2'd3;

    // Sources whose data is only available after EX (scratchpad read, input port)
    function automatic logic is_late_src(input logic [1:0] sel);
        return (sel == RF_SRC_SCR) || (sel == RF_SRC_IN);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller signal bundle.
// master: pipeline side (drives stage status, receives controls).
// slave : hazard controller.
// With HAZ_PERF_CNT_EN defined the bundle also carries the perf counters.
// Handshake note: there is no valid/ready pair here; every control is a
// level that applies to the current cycle only.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    import rat_pipe_pkg::*;

    logic [4:0] id_adr_x;
    logic [4:0] id_adr_y;
    logic       id_use_x;
    logic       id_use_y;
    logic       ex_rf_wr;
    logic [1:0] ex_rf_wr_sel;
    logic [4:0] ex_wb_addr;
    logic       ex_mem_busy;
    logic       br_mispredict;
    logic       int_req;
    logic       int_en;

    logic       pc_stall;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_nop;
    logic       idex_int;
    logic       int_ack;
    hz_state_t  state;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    modport master (
        output id_adr_x, id_adr_y, id_use_x, id_use_y,
        output ex_rf_wr, ex_rf_wr_sel, ex_wb_addr, ex_mem_busy,
        output br_mispredict, int_req, int_en,
        input  pc_stall, ifid_stall, ifid_flush, idex_nop, idex_int, int_ack,
        input  state
`ifdef HAZ_PERF_CNT_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_adr_x, id_adr_y, id_use_x, id_use_y,
        input  ex_rf_wr, ex_rf_wr_sel, ex_wb_addr, ex_mem_busy,
        input  br_mispredict, int_req, int_en,
        output pc_stall, ifid_stall, ifid_flush, idex_nop, idex_int, int_ack,
        output state
`ifdef HAZ_PERF_CNT_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// Saturating event counter used for hazard performance statistics.
module hazard_perf_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, sticking at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, mispredict flushes and
// interrupt entry sequencing (drain -> inject -> vector wait).
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import rat_pipe_pkg::*;
#(
    parameter int DRAIN_CYC = 2,
    parameter int VEC_WAIT  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipeline_hazard_ctrl_if.slave   hz
);

    localparam int CNT_MAX = (DRAIN_CYC > VEC_WAIT) ? DRAIN_CYC : VEC_WAIT;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYC - 1);
    localparam logic [CW-1:0] VEC_LD   = CW'(VEC_WAIT - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    hz_state_t     state;
    logic [CW-1:0] cnt;
    logic          luse;
    logic          pc_stall;
    logic          ifid_stall;
    logic          ifid_flush;
    logic          idex_nop;
    logic          idex_int;
    logic          int_ack;

    // Load-use hazard: EX result comes from a late source and ID reads it
    always_comb begin
        luse = hz.ex_rf_wr && is_late_src(hz.ex_rf_wr_sel) &&
               ((hz.id_use_x && (hz.id_adr_x == hz.ex_wb_addr)) ||
                (hz.id_use_y && (hz.id_adr_y == hz.ex_wb_addr)));
    end

    // Stage controls from current state and inputs; all forced low in reset
    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_nop   = 1'b0;
        idex_int   = 1'b0;
        int_ack    = 1'b0;
        if (rst_n) begin
            unique case (state)
                HZ_IDLE: begin
                    if (hz.br_mispredict) begin
                        ifid_flush = 1'b1;
                        idex_nop   = 1'b1;
                    end else if (luse) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_nop   = 1'b1;
                    end
                end
                HZ_DRAIN: begin
                    if (hz.br_mispredict) begin
                        ifid_flush = 1'b1;
                        idex_nop   = 1'b1;
                    end else begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_nop   = 1'b1;
                    end
                end
                HZ_INJECT: begin
                    idex_int   = 1'b1;
                    int_ack    = 1'b1;
                    pc_stall   = 1'b1;
                    ifid_flush = 1'b1;
                end
                HZ_VEC: begin
                    ifid_flush = 1'b1;
                    idex_nop   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Interrupt entry FSM with shared drain/vector-wait counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HZ_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                HZ_IDLE: begin
                    if (hz.int_req && hz.int_en && !hz.br_mispredict) begin
                        state <= HZ_DRAIN;
                        cnt   <= DRAIN_LD;
                    end
                end
                HZ_DRAIN: begin
                    if (!hz.int_req) begin
                        state <= HZ_IDLE;
                    end else if (hz.br_mispredict) begin
                        // flushed instructions restart the drain window
                        cnt <= DRAIN_LD;
                    end else if ((cnt == '0) && !hz.ex_mem_busy) begin
                        state <= HZ_INJECT;
                    end else if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end
                end
                HZ_INJECT: begin
                    state <= HZ_VEC;
                    cnt   <= VEC_LD;
                end
                HZ_VEC: begin
                    if (cnt == '0) begin
                        state <= HZ_IDLE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: state <= HZ_IDLE;
            endcase
        end
    end

    assign hz.pc_stall   = pc_stall;
    assign hz.ifid_stall = ifid_stall;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_nop   = idex_nop;
    assign hz.idex_int   = idex_int;
    assign hz.int_ack    = int_ack;
    assign hz.state      = state;

`ifdef HAZ_PERF_CNT_EN
    logic stall_inc;
    logic flush_inc;

    // A stall is counted only when the load-use bubble is actually issued
    always_comb begin
        stall_inc = rst_n && (state == HZ_IDLE) && !hz.br_mispredict && luse;
        flush_inc = rst_n && hz.br_mispredict &&
                    ((state == HZ_IDLE) || (state == HZ_DRAIN));
    end

    hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (hz.stall_cnt)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (hz.flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (DRAIN_CYC=2, VEC_WAIT=1, CNT_W=4).
// Perf-counter checks are compiled when HAZ_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;
    import rat_pipe_pkg::*;

    // {pc_stall, ifid_stall, ifid_flush, idex_nop, idex_int, int_ack}
    localparam logic [5:0] O_ZERO  = 6'b000000;
    localparam logic [5:0] O_STALL = 6'b110100;
    localparam logic [5:0] O_FLUSH = 6'b001100;
    localparam logic [5:0] O_INJ   = 6'b101011;
    localparam logic [5:0] O_VEC   = 6'b001100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(4)) bus ();

    pipeline_hazard_ctrl #(
        .DRAIN_CYC (2),
        .VEC_WAIT  (1),
        .CNT_W     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus.slave)
    );

    // clock
    always #5 clk = ~clk;

    logic [5:0] outs;
    assign outs = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush,
                   bus.idex_nop, bus.idex_int, bus.int_ack};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.id_adr_x      = 5'd0;
        bus.id_adr_y      = 5'd0;
        bus.id_use_x      = 1'b0;
        bus.id_use_y      = 1'b0;
        bus.ex_rf_wr      = 1'b0;
        bus.ex_rf_wr_sel  = RF_SRC_ALU;
        bus.ex_wb_addr    = 5'd0;
        bus.ex_mem_busy   = 1'b0;
        bus.br_mispredict = 1'b0;
        bus.int_req       = 1'b0;
        bus.int_en        = 1'b0;
    endtask

    task automatic set_luse_x(input logic [1:0] sel);
        bus.ex_rf_wr     = 1'b1;
        bus.ex_rf_wr_sel = sel;
        bus.ex_wb_addr   = 5'd5;
        bus.id_adr_x     = 5'd5;
        bus.id_use_x     = 1'b1;
    endtask

    task automatic expect_cyc(input string tag, input hz_state_t st, input logic [5:0] o);
        check({tag, "_st"}, 32'(bus.state), 32'(st));
        check({tag, "_out"}, 32'(outs), 32'(o));
    endtask

    // interrupt inject and nop must be mutually exclusive
    always @(negedge clk) begin
        check("mutex", 32'(bus.idex_int & bus.idex_nop), 32'd0);
    end

    // EX must hold a bubble during inject / vector wait
    always @(posedge clk) begin
        if (rst_n && ((bus.state == HZ_INJECT) || (bus.state == HZ_VEC)))
            check("br_legal", 32'(bus.br_mispredict), 32'd0);
    end

    initial begin
        clear_in();

        // ---- reset with pending interrupt and a load-use pattern
        rst_n = 1'b0;
        bus.int_req = 1'b1;
        bus.int_en  = 1'b1;
        set_luse_x(RF_SRC_SCR);
        tick();
        check("rst_out0", 32'(outs), 32'(O_ZERO));
        tick();
        check("rst_out1", 32'(outs), 32'(O_ZERO));
        clear_in();
        rst_n = 1'b1;
        #1;
        expect_cyc("rst_rel", HZ_IDLE, O_ZERO);
        tick();
        expect_cyc("rst_idle", HZ_IDLE, O_ZERO);

        // ---- load-use detection
        set_luse_x(RF_SRC_SCR);
        #1 check("luse_scr", 32'(outs), 32'(O_STALL));
        bus.ex_rf_wr_sel = RF_SRC_ALU;
        #1 check("luse_alu", 32'(outs), 32'(O_ZERO));
        bus.id_use_x = 1'b0;
        bus.id_use_y = 1'b1;
        bus.id_adr_y = 5'd7;
        bus.ex_wb_addr = 5'd7;
        bus.ex_rf_wr_sel = RF_SRC_IN;
        #1 check("luse_in_y", 32'(outs), 32'(O_STALL));
        bus.ex_rf_wr_sel = RF_SRC_SP;
        #1 check("luse_sp", 32'(outs), 32'(O_ZERO));
        bus.ex_rf_wr_sel = RF_SRC_SCR;
        bus.ex_rf_wr = 1'b0;
        #1 check("luse_nowr", 32'(outs), 32'(O_ZERO));
        bus.ex_rf_wr = 1'b1;
        bus.ex_wb_addr = 5'd6;
        #1 check("luse_addr", 32'(outs), 32'(O_ZERO));
        bus.ex_wb_addr = 5'd7;
        bus.id_use_y = 1'b0;
        #1 check("luse_nouse", 32'(outs), 32'(O_ZERO));
        tick();
        check("luse_state", 32'(bus.state), 32'(HZ_IDLE));

        // ---- mispredict overrides load-use
        clear_in();
        set_luse_x(RF_SRC_SCR);
        bus.br_mispredict = 1'b1;
        #1 check("mp_luse", 32'(outs), 32'(O_FLUSH));
        // mispredict also blocks interrupt entry
        bus.int_req = 1'b1;
        bus.int_en  = 1'b1;
        tick();
        clear_in();
        #1 expect_cyc("mp_blk", HZ_IDLE, O_ZERO);

        // ---- interrupt entry, no memory busy
        bus.int_req = 1'b1;
        bus.int_en  = 1'b1;
        #1 expect_cyc("int_c0", HZ_IDLE, O_ZERO);
        tick();
        expect_cyc("int_c1", HZ_DRAIN, O_STALL);
        tick();
        expect_cyc("int_c2", HZ_DRAIN, O_STALL);
        tick();
        bus.int_req = 1'b0;
        #1 expect_cyc("int_c3", HZ_INJECT, O_INJ);
        tick();
        expect_cyc("int_c4", HZ_VEC, O_VEC);
        tick();
        expect_cyc("int_c5", HZ_IDLE, O_ZERO);

        // interrupt disabled: stays idle
        bus.int_req = 1'b1;
        bus.int_en  = 1'b0;
        tick();
        expect_cyc("int_dis", HZ_IDLE, O_ZERO);
        clear_in();

        // ---- interrupt with EX busy for three extra cycles
        bus.int_req = 1'b1;
        bus.int_en  = 1'b1;
        bus.ex_mem_busy = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 5) bus.ex_mem_busy = 1'b0;
            #1 expect_cyc($sformatf("busy_c%0d", c), HZ_DRAIN, O_STALL);
        end
        tick();
        bus.int_req = 1'b0;
        #1 expect_cyc("busy_c6", HZ_INJECT, O_INJ);
        tick();
        expect_cyc("busy_c7", HZ_VEC, O_VEC);
        tick();
        expect_cyc("busy_c8", HZ_IDLE, O_ZERO);

        // ---- request withdrawn during drain: back to idle, no ack
        bus.int_req = 1'b1;
        bus.int_en  = 1'b1;
        tick();
        bus.int_req = 1'b0;
        #1 expect_cyc("drop_c1", HZ_DRAIN, O_STALL);
        tick();
        expect_cyc("drop_c2", HZ_IDLE, O_ZERO);
        tick();
        expect_cyc("drop_c3", HZ_IDLE, O_ZERO);
        clear_in();

        // ---- mispredict during drain reloads the drain counter
        bus.int_req = 1'b1;
        bus.int_en  = 1'b1;
        tick();
        bus.br_mispredict = 1'b1;
        #1 expect_cyc("mpd_c1", HZ_DRAIN, O_FLUSH);
        tick();
        bus.br_mispredict = 1'b0;
        #1 expect_cyc("mpd_c2", HZ_DRAIN, O_STALL);
        tick();
        expect_cyc("mpd_c3", HZ_DRAIN, O_STALL);
        tick();
        bus.int_req = 1'b0;
        #1 expect_cyc("mpd_c4", HZ_INJECT, O_INJ);
        tick();
        expect_cyc("mpd_c5", HZ_VEC, O_VEC);
        tick();
        expect_cyc("mpd_c6", HZ_IDLE, O_ZERO);
        clear_in();

`ifdef HAZ_PERF_CNT_EN
        // ---- perf counters (CNT_W=4)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1 check("pc_rst_s", 32'(bus.stall_cnt), 32'd0);
        check("pc_rst_f", 32'(bus.flush_cnt), 32'd0);
        set_luse_x(RF_SRC_IN);
        for (int i = 0; i < 10; i++) tick();
        check("pc_stall10", 32'(bus.stall_cnt), 32'd10);
        for (int i = 0; i < 10; i++) tick();
        check("pc_stall_sat", 32'(bus.stall_cnt), 32'd15);
        bus.br_mispredict = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        clear_in();
        #1 check("pc_flush3", 32'(bus.flush_cnt), 32'd3);
        check("pc_stall_hold", 32'(bus.stall_cnt), 32'd15);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
